// File: rtl/mouse_pos_latch_if.sv
// vga_if: display timing bundle shared between pipeline stages.
// Only the vertical blanking flag is carried here.
interface vga_if;
    logic vblnk;

    modport IN  (input  vblnk);
    modport OUT (output vblnk);
endinterface

// File: rtl/mouse_pos_latch.sv
// mouse_pos_latch: holds mouse position/click in a shadow and commits
// them to the overlay stage only on the rising edge of vertical blank.
// Ports: clk, rst_n (sync, active-low), in (vga_if.IN, vblnk used),
//   xpos_raw/ypos_raw/new_event/left from the mouse controller,
//   xpos/ypos (frame-stable), click (1-cycle commit pulse), pending.
// Option: define MOUSE_POS_CLAMP_EN to clamp x/y to H_MAX/V_MAX.
module mouse_pos_latch #(
    parameter int H_MAX = 1023,
    parameter int V_MAX = 767
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_if.IN           in,
    input  logic [11:0] xpos_raw,
    input  logic [11:0] ypos_raw,
    input  logic        new_event,
    input  logic        left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        click,
    output logic        pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [11:0] H_LIM = 12'(H_MAX);
    localparam logic [11:0] V_LIM = 12'(V_MAX);

    function automatic logic [11:0] clamp_x(input logic [11:0] v);
        return (v > H_LIM) ? H_LIM : v;
    endfunction

    function automatic logic [11:0] clamp_y(input logic [11:0] v);
        return (v > V_LIM) ? V_LIM : v;
    endfunction

    state_t      state;
    logic [11:0] shadow_x;
    logic [11:0] shadow_y;
    logic        click_hold;
    logic        left_d;
    logic        vblnk_d;

    logic [11:0] cap_x;
    logic [11:0] cap_y;
    logic        frame_edge;
    logic        press;
    logic        commit;
    logic [11:0] next_x;
    logic [11:0] next_y;
    logic        next_hold;

`ifdef MOUSE_POS_CLAMP_EN
    assign cap_x = clamp_x(xpos_raw);
    assign cap_y = clamp_y(ypos_raw);
`else
    assign cap_x = xpos_raw;
    assign cap_y = ypos_raw;
`endif

    assign frame_edge = in.vblnk & ~vblnk_d;
    assign press      = new_event & left & ~left_d;

    // Values arriving on the commit cycle bypass the shadow.
    assign next_x    = new_event ? cap_x : shadow_x;
    assign next_y    = new_event ? cap_y : shadow_y;
    assign next_hold = click_hold | press;

    // Idle with a frame edge only commits when a bypassed event exists;
    // otherwise shadow already equals the outputs.
    assign commit = frame_edge & ((state == HOLD) | new_event);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow_x   <= '0;
            shadow_y   <= '0;
            click_hold <= 1'b0;
            left_d     <= 1'b0;
            vblnk_d    <= 1'b0;
            xpos       <= '0;
            ypos       <= '0;
            click      <= 1'b0;
            pending    <= 1'b0;
        end else begin
            vblnk_d <= in.vblnk;
            click   <= 1'b0;

            if (new_event) begin
                shadow_x <= cap_x;
                shadow_y <= cap_y;
                left_d   <= left;
            end

            if (commit) begin
                xpos       <= next_x;
                ypos       <= next_y;
                click      <= next_hold;
                click_hold <= 1'b0;
                state      <= IDLE;
                pending    <= 1'b0;
            end else if (new_event) begin
                click_hold <= next_hold;
                state      <= HOLD;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mouse_pos_latch.sv
// tb_mouse_pos_latch: directed scenario bench for mouse_pos_latch.
// Each task drives one scenario and checks outputs after the clock edge.
module tb_mouse_pos_latch;

    logic        clk;
    logic        rst_n;
    logic [11:0] xpos_raw;
    logic [11:0] ypos_raw;
    logic        new_event;
    logic        left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        click;
    logic        pending;

    int checks;
    int failures;

    vga_if vif ();

    mouse_pos_latch #(
        .H_MAX(1023),
        .V_MAX(767)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (vif.IN),
        .xpos_raw (xpos_raw),
        .ypos_raw (ypos_raw),
        .new_event(new_event),
        .left     (left),
        .xpos     (xpos),
        .ypos     (ypos),
        .click    (click),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input int x, input int y, input logic l);
        xpos_raw  = 12'(x);
        ypos_raw  = 12'(y);
        left      = l;
        new_event = 1'b1;
        tick();
        new_event = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0) begin
            failures++;
            $display("FAIL reset_pos got=%0d/%0d exp=0/0", xpos, ypos);
        end
        checks++;
        if (click !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got click=%b pend=%b exp=0/0",
                     click, pending);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ev(100, 200, 1'b0);
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL basic_pending got=%b exp=1", pending);
        end
        tick();
        tick();
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0) begin
            failures++;
            $display("FAIL basic_hold got=%0d/%0d exp=0/0", xpos, ypos);
        end
        vif.vblnk = 1'b1;
        tick();
        checks++;
        if (xpos !== 12'd100 || ypos !== 12'd200) begin
            failures++;
            $display("FAIL basic_commit got=%0d/%0d exp=100/200",
                     xpos, ypos);
        end
        checks++;
        if (pending !== 1'b0 || click !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags got pend=%b click=%b exp=0/0",
                     pending, click);
        end
        tick();
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        logic [11:0] ex;
        logic [11:0] ey;
`ifdef MOUSE_POS_CLAMP_EN
        ex = 12'd1023;
        ey = 12'd767;
`else
        ex = 12'd1500;
        ey = 12'd900;
`endif
        ev(1500, 900, 1'b0);
        vif.vblnk = 1'b1;
        tick();
        checks++;
        if (xpos !== ex || ypos !== ey) begin
            failures++;
            $display("FAIL clamp got=%0d/%0d exp=%0d/%0d",
                     xpos, ypos, ex, ey);
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_multi();
        ev(10, 10, 1'b0);
        ev(20, 20, 1'b1);
        ev(30, 30, 1'b1);
        checks++;
        if (click !== 1'b0 || xpos !== 12'd900 && xpos !== 12'd767
            && xpos !== 12'd1023 && xpos !== 12'd1500) begin
            failures++;
            $display("FAIL multi_pre got click=%b x=%0d exp no change",
                     click, xpos);
        end
        vif.vblnk = 1'b1;
        tick();
        checks++;
        if (xpos !== 12'd30 || ypos !== 12'd30 || click !== 1'b1) begin
            failures++;
            $display("FAIL multi_commit got=%0d/%0d c=%b exp=30/30 c=1",
                     xpos, ypos, click);
        end
        tick();
        checks++;
        if (click !== 1'b0) begin
            failures++;
            $display("FAIL multi_click_width got=%b exp=0", click);
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        xpos_raw  = 12'd5;
        ypos_raw  = 12'd6;
        left      = 1'b0;
        new_event = 1'b1;
        vif.vblnk = 1'b1;
        tick();
        new_event = 1'b0;
        checks++;
        if (xpos !== 12'd5 || ypos !== 12'd6 || pending !== 1'b0) begin
            failures++;
            $display("FAIL bypass got=%0d/%0d p=%b exp=5/6 p=0",
                     xpos, ypos, pending);
        end
        vif.vblnk = 1'b0;
        tick();
        xpos_raw  = 12'd7;
        ypos_raw  = 12'd8;
        left      = 1'b1;
        new_event = 1'b1;
        vif.vblnk = 1'b1;
        tick();
        new_event = 1'b0;
        checks++;
        if (xpos !== 12'd7 || click !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL bypass_press got x=%0d c=%b p=%b exp=7 1 0",
                     xpos, click, pending);
        end
        tick();
        checks++;
        if (click !== 1'b0) begin
            failures++;
            $display("FAIL bypass_click_width got=%b exp=0", click);
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_vblnk_held();
        vif.vblnk = 1'b1;
        tick();
        ev(40, 41, 1'b0);
        tick();
        tick();
        checks++;
        if (xpos !== 12'd7 || pending !== 1'b1) begin
            failures++;
            $display("FAIL held_blank got x=%0d p=%b exp=7 p=1",
                     xpos, pending);
        end
        vif.vblnk = 1'b0;
        tick();
        vif.vblnk = 1'b1;
        tick();
        checks++;
        if (xpos !== 12'd40 || ypos !== 12'd41 || pending !== 1'b0) begin
            failures++;
            $display("FAIL held_commit got=%0d/%0d p=%b exp=40/41 p=0",
                     xpos, ypos, pending);
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        ev(50, 51, 1'b1);
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pending got=%b exp=1", pending);
        end
        rst_n     = 1'b0;
        xpos_raw  = 12'd60;
        ypos_raw  = 12'd61;
        new_event = 1'b1;
        tick();
        tick();
        new_event = 1'b0;
        rst_n     = 1'b1;
        tick();
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state got=%0d/%0d p=%b exp=0/0 p=0",
                     xpos, ypos, pending);
        end
        vif.vblnk = 1'b1;
        tick();
        checks++;
        if (click !== 1'b0 || xpos !== 12'd0) begin
            failures++;
            $display("FAIL midrst_noclick got c=%b x=%0d exp=0 0",
                     click, xpos);
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    task automatic test_idle_frames();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 7; c++) begin
                vif.vblnk = (c >= 4);
                tick();
                checks++;
                if (click !== 1'b0 || pending !== 1'b0 ||
                    xpos !== 12'd0 || ypos !== 12'd0) begin
                    failures++;
                    $display("FAIL idle f=%0d c=%0d got c=%b p=%b %0d/%0d",
                             f, c, click, pending, xpos, ypos);
                end
            end
        end
        vif.vblnk = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        xpos_raw  = '0;
        ypos_raw  = '0;
        new_event = 1'b0;
        left      = 1'b0;
        vif.vblnk = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_multi();
        test_bypass();
        test_vblnk_held();
        test_reset_mid_hold();
        test_idle_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
